present_cmd_loader: RTL
=======================

PRESENT_CMD_LOADER -- requirements
Module: present_cmd_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 s_data  input  8  command byte stream, MSB-first.
REQ-003 s_valid  input  1  s_data is valid.
REQ-004 s_ready  output  1  loader accepts a byte; a transfer occurs when s_valid && s_ready.
REQ-005 core_busy  input  1  downstream PRESENT core is busy; an issue is held while high.
REQ-006 pl  output  2  load strobe: pl[0] = plaintext load, pl[1] = key load; never both set.
REQ-007 in  output  80  load payload, valid while pl != 0.
REQ-008 err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-009 Frame format SHALL be one opcode byte followed by a payload: 0x01 = plaintext (8 bytes), 0x02 = key (10 bytes); first payload byte is most significant.
REQ-010 FSM states SHALL be IDLE, DATA, CHK (only when the macro is defined) and ISSUE; reset state is IDLE.
REQ-011 IDLE: s_ready=1; a valid opcode goes to DATA, loads the byte counter with 7 or 9 and clears the shift register.
REQ-012 IDLE, any other opcode: the byte is consumed, err pulses on the next cycle and the FSM stays in IDLE.
REQ-013 DATA: s_ready=1; each accepted byte shifts in as the shift register LSB byte and the counter decrements; on the byte accepted at counter 0, go to CHK if the macro is defined, else to ISSUE.
REQ-014 s_valid low in any state SHALL stall without state change; there is no timeout.
REQ-015 ISSUE: s_ready=0; if core_busy=0, drive pl one-hot for exactly one cycle and return to IDLE; if core_busy=1, hold in ISSUE with pl=0.
REQ-016 Plaintext payload SHALL appear as in[63:0] with in[79:64]=0; key payload occupies in[79:0].
REQ-017 in SHALL hold its last value when pl=0 and SHALL never be X/Z after reset.
REQ-018 Latency: pl asserts on the first cycle after the last payload byte is accepted, or after the check byte if the macro is defined, provided core_busy=0.
REQ-019 pl SHALL be registered; core_busy is sampled in the same cycle that pl asserts, so the decision uses a registered FSM state plus the live core_busy.

Reset
REQ-020 Asserting rst_n low SHALL immediately force pl=0, in=0, err=0, s_ready=0, counter=0 and state IDLE, including mid-frame; any partial frame is discarded.
REQ-021 s_ready SHALL rise on the first clk edge after rst_n deasserts.

Configuration
REQ-022 Macro PRESENT_LOADER_CHKSUM_EN: when defined, the payload is followed by one check byte equal to the XOR of the opcode and all payload bytes.
REQ-023 On a check-byte match, go to ISSUE; on a mismatch, err pulses, pl never asserts, and the FSM returns to IDLE.
REQ-024 When the macro is undefined, there is no CHK state, no check byte, and err is driven only by a bad opcode.

Structure
REQ-025 Shared package present_pkg SHALL hold: OPC_PT=8'h01, OPC_KEY=8'h02, PT_BYTES=8, KEY_BYTES=10, KEY_W=80, BLK_W=64, and the loader state enum.
REQ-026 One sub-module, present_byte_shreg (80-bit, byte-wide, clear and shift-enable), SHALL be used; the FSM and counter stay in present_cmd_loader.

Verification
REQ-027 Bytes 01,01,23,45,67,89,AB,CD,EF with core_busy=0 -> one cycle of pl=2'b01 and in=80'h0000_0123456789ABCDEF.
REQ-028 Bytes 02, then ten bytes of FF, with core_busy high for 5 cycles after the last byte -> pl=0 and s_ready=0 during the hold, then a single cycle of pl=2'b10 and in=all ones.
REQ-029 Opcode 7E, then 01 plus 8 payload bytes -> err pulses once, and the second frame issues normally.
REQ-030 rst_n pulsed low after the 4th key byte, then a fresh plaintext frame -> no pl from the aborted frame; plaintext issues correctly.
REQ-031 With PRESENT_LOADER_CHKSUM_EN: frame 01, 00 x8, check byte 01 -> pl=2'b01; the same frame with check byte 00 -> err pulses and no pl.
REQ-032 Random s_valid gaps (50%) across 20 mixed frames -> payloads match the model, and pl is never X and never 2'b11.

Source files
------------

// File: rtl/present_pkg.sv
// Shared constants and loader state encoding for the PRESENT command loader.
// PRESENT_LOADER_CHKSUM_EN adds the CHK state used for the trailing check byte.
package present_pkg;

  localparam logic [7:0] OPC_PT  = 8'h01;
  localparam logic [7:0] OPC_KEY = 8'h02;
  localparam int PT_BYTES  = 8;
  localparam int KEY_BYTES = 10;
  localparam int KEY_W     = 80;
  localparam int BLK_W     = 64;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
`ifdef PRESENT_LOADER_CHKSUM_EN
    ST_CHK   = 2'd2,
`endif
    ST_ISSUE = 2'd3
  } loader_state_t;

endpackage

// File: rtl/present_byte_shreg.sv
// 80-bit byte-wide shift register; new bytes enter at the LSB end so the
// first byte shifted in ends up most significant.
module present_byte_shreg
  import present_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic [7:0]       din,
  output logic [KEY_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (shift_en)
      q <= {q[KEY_W-9:0], din};
  end

endmodule

// File: rtl/present_cmd_loader.sv
// Byte-stream command loader feeding plaintext/key loads into a PRESENT core.
// Build option PRESENT_LOADER_CHKSUM_EN: trailing XOR check byte per frame.
//
//   state | meaning
//   IDLE  | waiting for opcode byte
//   DATA  | collecting payload bytes, cnt = bytes remaining minus one
//   CHK   | waiting for check byte (checksum build only)
//   ISSUE | payload complete, waiting for core_busy low to strobe pl
module present_cmd_loader
  import present_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             core_busy,
  output logic [1:0]       pl,
  output logic [KEY_W-1:0] in,
  output logic             err
);

  loader_state_t    state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             is_key, is_key_nx;
  logic             rdy_en;
  logic             err_nx;
  logic             sh_clr, sh_shift;
  logic             xfer;
  logic [KEY_W-1:0] sh_q, payload, in_hold;
`ifdef PRESENT_LOADER_CHKSUM_EN
  logic [7:0]       chk, chk_nx;
`endif

  present_byte_shreg u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (sh_clr),
    .shift_en (sh_shift),
    .din      (s_data),
    .q        (sh_q)
  );

  // rdy_en keeps s_ready low until the first edge after reset release
  always_comb begin
`ifdef PRESENT_LOADER_CHKSUM_EN
    s_ready = rdy_en && (state == ST_IDLE || state == ST_DATA || state == ST_CHK);
`else
    s_ready = rdy_en && (state == ST_IDLE || state == ST_DATA);
`endif
  end

  assign xfer    = s_valid && s_ready;
  assign payload = is_key ? sh_q : {{(KEY_W-BLK_W){1'b0}}, sh_q[BLK_W-1:0]};

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    is_key_nx = is_key;
    err_nx    = 1'b0;
    sh_clr    = 1'b0;
    sh_shift  = 1'b0;
    pl        = 2'b00;
`ifdef PRESENT_LOADER_CHKSUM_EN
    chk_nx    = chk;
`endif
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          if (s_data == OPC_PT || s_data == OPC_KEY) begin
            state_nx  = ST_DATA;
            is_key_nx = (s_data == OPC_KEY);
            cnt_nx    = (s_data == OPC_KEY) ? CNT_W'(KEY_BYTES-1) : CNT_W'(PT_BYTES-1);
            sh_clr    = 1'b1;
`ifdef PRESENT_LOADER_CHKSUM_EN
            chk_nx    = s_data;
`endif
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          sh_shift = 1'b1;
`ifdef PRESENT_LOADER_CHKSUM_EN
          chk_nx   = chk ^ s_data;
`endif
          if (cnt == '0)
`ifdef PRESENT_LOADER_CHKSUM_EN
            state_nx = ST_CHK;
`else
            state_nx = ST_ISSUE;
`endif
          else
            cnt_nx = cnt - 1'b1;
        end
      end
`ifdef PRESENT_LOADER_CHKSUM_EN
      ST_CHK: begin
        if (xfer) begin
          if (s_data == chk) begin
            state_nx = ST_ISSUE;
          end else begin
            err_nx   = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
`endif
      ST_ISSUE: begin
        // pl decodes the registered state against live core_busy
        if (!core_busy) begin
          pl       = is_key ? 2'b10 : 2'b01;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // in shows the payload during the strobe and holds it afterwards
  assign in = (pl != 2'b00) ? payload : in_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      is_key  <= 1'b0;
      rdy_en  <= 1'b0;
      err     <= 1'b0;
      in_hold <= '0;
`ifdef PRESENT_LOADER_CHKSUM_EN
      chk     <= '0;
`endif
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      is_key <= is_key_nx;
      rdy_en <= 1'b1;
      err    <= err_nx;
      if (pl != 2'b00)
        in_hold <= payload;
`ifdef PRESENT_LOADER_CHKSUM_EN
      chk    <= chk_nx;
`endif
    end
  end

endmodule
